mfp_ahb_master: RTL

- AHB-lite initiator (bus master) that turns a simple client request/response handshake into single AHB-lite transfers (HBURST=SINGLE) on the system bus.
- Drives the slave side of the system interconnect (address decoder plus read-data mux) from a second on-chip client, e.g. a DMA or debug engine.
- Handles pipelined address/data phases, HREADY wait states, and the two-cycle HRESP error response.

---
 rtl/mfp_ahb_master_pkg.sv | 31 +++
 rtl/mfp_ahb_master_wdt.sv | 35 +++
 rtl/mfp_ahb_master.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mfp_ahb_master_pkg.sv
// mfp_ahb_master_pkg
//   Shared AHB-lite encodings, master state encodings and the request
//   legality helper used by mfp_ahb_master.
package mfp_ahb_master_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_ADDR = 2'b01;
    localparam logic [1:0] ST_DATA = 2'b10;
    localparam logic [1:0] ST_ERR2 = 2'b11;

    // A request is legal when the size is byte/half/word and the address
    // is naturally aligned for that size.
    function automatic logic req_legal(input logic [2:0] size, input logic [1:0] addr_lo);
        case (size)
            HSIZE_BYTE: req_legal = 1'b1;
            HSIZE_HALF: req_legal = !addr_lo[0];
            HSIZE_WORD: req_legal = (addr_lo == 2'b00);
            default:    req_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mfp_ahb_master_wdt.sv
// mfp_ahb_master_wdt
//   Wait-state watchdog for mfp_ahb_master. Counts data-phase cycles with
//   HREADY low and flags expiry on the cycle that would reach TIMEOUT_CYCLES.
// Ports:
//   HCLK, HRESETn - bus clock, asynchronous active-low reset
//   clr           - data-phase entry, restarts the count
//   inc           - a DATA/ERR2 cycle with HREADY low
//   expire        - this stalled cycle is the TIMEOUT_CYCLES-th one
module mfp_ahb_master_wdt #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    assign expire = inc && (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !expire) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mfp_ahb_master.sv
// mfp_ahb_master
//   AHB-lite initiator: converts a client valid/ready request into single
//   (HBURST=SINGLE) AHB-lite transfers and returns a one-cycle response
//   pulse with read data and an error flag.
// Ports:
//   HCLK, HRESETn              - bus clock, asynchronous active-low reset
//   req_valid/req_ready        - client request handshake
//   req_write/addr/size/wdata  - request fields
//   rsp_valid/rsp_rdata/rsp_err- completion pulse, read data, error flag
//   HADDR..HWDATA              - AHB-lite master outputs
//   HRDATA, HREADY, HRESP      - AHB-lite slave responses
// Configuration:
//   MFP_AHB_MASTER_TIMEOUT_EN  - when defined, abandons a transfer after
//                                TIMEOUT_CYCLES stalled data-phase cycles.
module mfp_ahb_master
    import mfp_ahb_master_pkg::*;
#(
    parameter logic [3:0]  HPROT_VAL      = 4'b0011,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    logic [1:0]  state;
    logic [31:0] wdata_q;
    logic        bad_q;
    logic        accept;
    logic        legal;
    logic        tmo_expire;

    assign req_ready = (state == ST_IDLE) || ((state == ST_DATA) && HREADY && !HRESP);
    assign accept    = req_valid && req_ready;
    assign legal     = req_legal(req_size, req_addr[1:0]);

    assign HBURST    = HBURST_SINGLE;
    assign HMASTLOCK = 1'b0;
    assign HPROT     = HPROT_VAL;

`ifdef MFP_AHB_MASTER_TIMEOUT_EN
    logic tmo_clr;
    logic tmo_inc;

    assign tmo_clr = (state == ST_ADDR) && !bad_q && HREADY;
    assign tmo_inc = ((state == ST_DATA) || (state == ST_ERR2)) && !HREADY;

    mfp_ahb_master_wdt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdt (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .clr     (tmo_clr),
        .inc     (tmo_inc),
        .expire  (tmo_expire)
    );
`else
    // TIMEOUT_CYCLES has no effect in this build.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign tmo_expire     = 1'b0;
`endif

    // Address-phase fields and write data are captured only for transfers
    // that actually reach the bus.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            HADDR   <= '0;
            HWRITE  <= 1'b0;
            HSIZE   <= HSIZE_WORD;
            wdata_q <= '0;
        end else if (accept && legal) begin
            HADDR   <= req_addr;
            HWRITE  <= req_write;
            HSIZE   <= req_size;
            wdata_q <= req_wdata;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            HTRANS    <= HTRANS_IDLE;
            HWDATA    <= '0;
            bad_q     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (legal) begin
                            state  <= ST_ADDR;
                            HTRANS <= HTRANS_NONSEQ;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    // An illegal request pipelined behind a completing
                    // transfer parks here for one idle cycle so its error
                    // pulse does not collide with the previous response.
                    if (bad_q) begin
                        bad_q     <= 1'b0;
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else if (HREADY) begin
                        state  <= ST_DATA;
                        HTRANS <= HTRANS_IDLE;
                        HWDATA <= wdata_q;
                    end
                end
                ST_DATA: begin
                    if (tmo_expire) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else if (HRESP) begin
                        if (HREADY) begin
                            state     <= ST_IDLE;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            state  <= ST_ERR2;
                            HTRANS <= HTRANS_IDLE;
                        end
                    end else if (HREADY) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        if (!HWRITE) begin
                            rsp_rdata <= HRDATA;
                        end
                        if (accept) begin
                            state <= ST_ADDR;
                            if (legal) begin
                                HTRANS <= HTRANS_NONSEQ;
                            end else begin
                                bad_q <= 1'b1;
                            end
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_ERR2: begin
                    if (tmo_expire || HREADY) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    HTRANS <= HTRANS_IDLE;
                end
            endcase
        end
    end

endmodule
